mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Sequencer between the JTAG data/instruction register logic and the 256x16 program memory (mem_model in simulation, real macro in silicon).
- Converts single-cycle valid/ready requests into timed memory accesses: holds mem_sel, mem_we, mem_addr and mem_wdata stable for the macro's minimum write/read windows.
- Captures read data at the end of the read window and returns a one-cycle response pulse.
- Enforces an inter-access recovery gap so the memory's internal timing restarts cleanly.

Parameters:
- WR_CYCLES, 10, clk cycles mem_sel is held high for a write (10 x 10ns = 100ns, at least 86ns memory write time); legal range 1..255.
- RD_CYCLES, 8, clk cycles mem_sel is held high for a read before mem_rdata is captured (80ns, at least 70ns access time plus one memory-clock register stage); legal range 1..255.
- RECOV_CYCLES, 1, clk cycles spent in RECOVER with mem_sel low; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present; requester holds it and all req_* fields stable until accepted
- req_ready  out  1  controller idle; 1 iff state==IDLE (combinational from state)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  8  word address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse on access completion (reads and writes)
- rsp_we  out  1  type of the completed access, valid with rsp_valid
- rsp_rdata  out  16  captured read data; holds its value until the next read completes
- mem_sel  out  1  memory select
- mem_we  out  1  memory write enable
- mem_addr  out  8  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_sel, mem_we, rsp_valid and rsp_we = 0.
  - mem_addr, mem_wdata and rsp_rdata = 0.
  - Counter = 0.
  - req_ready=1 (state is IDLE).
- All outputs except req_ready are registered.
- States: IDLE, ACCESS, RECOVER. The counter width covers 255.
- IDLE:
  - On an edge with req_valid=1 (accept edge E0): load mem_addr<=req_addr, mem_wdata<=req_wdata, mem_we<=req_we and rsp_we<=req_we.
  - Same edge: mem_sel<=1, cnt<=0, go to ACCESS.
- ACCESS:
  - cnt increments every edge. Let N = WR_CYCLES if mem_we, else RD_CYCLES.
  - At edge EN (cnt==N-1): mem_sel<=0, mem_we<=0, rsp_valid<=1, cnt<=0, go to RECOVER.
  - For a read, the same edge also loads rsp_rdata<=mem_rdata.
  - mem_sel is therefore high for exactly N cycles. mem_we, mem_addr and mem_wdata are constant over that whole window.
- RECOVER:
  - rsp_valid<=0 on the first edge; cnt increments.
  - At cnt==RECOV_CYCLES-1, go to IDLE.
- Latency and back-to-back timing:
  - rsp_valid is high during cycle EN..EN+1.
  - Earliest next accept edge is EN+RECOV_CYCLES+1, so mem_sel is low for at least RECOV_CYCLES+1 cycles between accesses.
  - Back-to-back throughput is one access per N+RECOV_CYCLES+1 cycles.
- req_* inputs are ignored outside IDLE; changes while busy have no effect.
- mem_addr and mem_wdata keep their last values after an access and change only on accept.
- Reset mid-operation:
  - mem_sel drops asynchronously and no rsp_valid is produced.
  - A write aborted before WR_CYCLES may leave the word unwritten; that is the requester's responsibility.
  - After rst_n rises, the controller is IDLE and ready.
- Simultaneous events: req_valid at the same edge ACCESS completes is not accepted (req_ready=0); it is accepted only in IDLE.

Test Plan (clk 10ns, default parameters):
- Write 0xA5A5 to 0x12, then read 0x12:
  - Write: mem_sel high exactly 10 cycles with mem_we=1, addr 0x12; rsp_valid pulse with rsp_we=1.
  - Read: mem_sel high 8 cycles with mem_we=0; rsp_valid with rsp_we=0 and rsp_rdata=0xA5A5.
- Back-to-back, req_valid held high (write 0x00=0xFFFF, write 0xFF=0x0000, read 0x00, read 0xFF):
  - req_ready low while busy; mem_sel low exactly 2 cycles between accesses.
  - Reads return 0xFFFF then 0x0000; each access starts 2 cycles after the previous completes.
- Reset during read, rst_n=0 at ACCESS cycle 4 of a read of 0x12:
  - mem_sel=0 immediately; no rsp_valid; rsp_rdata=0.
  - After release, read 0x12 returns 0xA5A5.
- Aborted write, write 0x1234 to 0x12 with reset at ACCESS cycle 5 (50ns, under 86ns):
  - Subsequent read of 0x12 returns 0xA5A5 (word unchanged).
- Inputs changed while busy (req_addr/req_wdata changed during ACCESS of write 0x34=0x5555):
  - mem_addr/mem_wdata stay 0x34/0x5555 for all 10 cycles; read 0x34 returns 0x5555.
- Parameter override WR_CYCLES=1, RD_CYCLES=1, RECOV_CYCLES=3:
  - mem_sel high 1 cycle per access; gap 4 cycles.
  - Counter/FSM timing checked by assertion (memory data not checked).

Source files
------------

// File: rtl/mem_ctrl.sv
// Sequencer between JTAG register logic and the 256x16 program memory.
// Stretches one-cycle requests into timed select windows with a recovery gap.
module mem_ctrl #(
  parameter int unsigned WR_CYCLES    = 10,
  parameter int unsigned RD_CYCLES    = 8,
  parameter int unsigned RECOV_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [15:0] rsp_rdata,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

  localparam logic [7:0] WrLast    = 8'(WR_CYCLES - 1);
  localparam logic [7:0] RdLast    = 8'(RD_CYCLES - 1);
  localparam logic [7:0] RecovLast = 8'(RECOV_CYCLES - 1);

  state_e      r_state, w_state;
  logic [7:0]  r_cnt, w_cnt;
  logic        r_mem_sel, w_mem_sel;
  logic        r_mem_we, w_mem_we;
  logic [7:0]  r_mem_addr, w_mem_addr;
  logic [15:0] r_mem_wdata, w_mem_wdata;
  logic        r_rsp_valid, w_rsp_valid;
  logic        r_rsp_we, w_rsp_we;
  logic [15:0] r_rsp_rdata, w_rsp_rdata;
  logic [7:0]  w_last;

  // mem_we is only high during a write window, so it selects the window length.
  assign w_last = r_mem_we ? WrLast : RdLast;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_mem_sel   = r_mem_sel;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_rsp_valid = r_rsp_valid;
    w_rsp_we    = r_rsp_we;
    w_rsp_rdata = r_rsp_rdata;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_mem_addr  = req_addr;
          w_mem_wdata = req_wdata;
          w_mem_we    = req_we;
          w_rsp_we    = req_we;
          w_mem_sel   = 1'b1;
          w_cnt       = 8'd0;
          w_state     = StAccess;
        end
      end
      StAccess: begin
        if (r_cnt == w_last) begin
          w_mem_sel   = 1'b0;
          w_mem_we    = 1'b0;
          w_rsp_valid = 1'b1;
          w_cnt       = 8'd0;
          w_state     = StRecover;
          if (!r_mem_we) w_rsp_rdata = mem_rdata;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      StRecover: begin
        w_rsp_valid = 1'b0;
        if (r_cnt == RecovLast) begin
          w_cnt   = 8'd0;
          w_state = StIdle;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 8'd0;
      r_mem_sel   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 8'd0;
      r_mem_wdata <= 16'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= 16'd0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_mem_sel   <= w_mem_sel;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_we    <= w_rsp_we;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = r_rsp_valid;
  assign rsp_we    = r_rsp_we;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_sel   = r_mem_sel;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: timed memory model, reference memory array, and a
// second instance with short windows to check the parameterised timing.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        rsp_valid, rsp_we;
  logic [15:0] rsp_rdata;
  logic        mem_sel, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'd0;

  logic        p_req_valid = 1'b0;
  logic        p_req_ready;
  logic        p_req_we = 1'b0;
  logic        p_rsp_valid, p_rsp_we, p_mem_sel, p_mem_we;
  logic [15:0] p_rsp_rdata, p_mem_wdata;
  logic [7:0]  p_mem_addr;
  logic [15:0] p_mem_rdata = 16'd0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_ctrl #(.WR_CYCLES(1), .RD_CYCLES(1), .RECOV_CYCLES(3)) u_par (
    .clk(clk), .rst_n(rst_n),
    .req_valid(p_req_valid), .req_ready(p_req_ready), .req_we(p_req_we),
    .req_addr(8'h5A), .req_wdata(16'h1111),
    .rsp_valid(p_rsp_valid), .rsp_we(p_rsp_we), .rsp_rdata(p_rsp_rdata),
    .mem_sel(p_mem_sel), .mem_we(p_mem_we), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata)
  );

  // Memory model: a write lands only after 9 select cycles (>= 86ns); reads are registered.
  logic [15:0] mem [256];
  int wcnt = 0;
  always @(posedge clk) begin
    if (mem_sel && mem_we) begin
      if (wcnt == 8) mem[mem_addr] <= mem_wdata;
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Reference view of memory contents and last returned read data.
  logic [15:0] ref_mem [256];
  logic [15:0] last_rd = 16'd0;

  int sl, rb, ac, rc;
  bit so, rs, po, tm;
  logic rw;
  logic [15:0] rd;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request at a negedge and measures the resulting access.
  task automatic drive_access(input logic we, input logic [7:0] a, input logic [15:0] d,
                              input bit hold, input bit scramble, input int rst_at);
    int b;
    sl = 0; so = 1; rb = 0; rs = 0; rw = 0; rd = 0; po = 0; ac = 0; rc = 0; tm = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    b = 0;
    while (!req_ready && b < 50) begin @(negedge clk); b++; end
    if (!req_ready) begin tm = 1; req_valid = 1'b0; return; end
    @(negedge clk);
    ac = cyc;
    if (!hold) req_valid = 1'b0;
    b = 0;
    while (mem_sel && b < 300) begin
      sl++;
      if (mem_addr !== a || mem_wdata !== d || mem_we !== we || rsp_valid !== 1'b0) so = 0;
      if (req_ready) rb++;
      if (scramble) begin
        req_addr = 8'($urandom); req_wdata = 16'($urandom); req_we = 1'($urandom);
      end
      if (rst_at != 0 && sl == rst_at) begin rst_n = 1'b0; #1; return; end
      @(negedge clk);
      b++;
    end
    if (b >= 300) tm = 1;
    rs = rsp_valid; rw = rsp_we; rd = rsp_rdata; rc = cyc;
    @(negedge clk);
    po = (rsp_valid === 1'b0);
    if (we) ref_mem[a] = d; else last_rd = ref_mem[a];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    if ({mem_sel, mem_we, rsp_valid, rsp_we} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {mem_sel, mem_we, rsp_valid, rsp_we});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== 40'd0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, rsp_rdata});
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_write_read();
    drive_access(1'b1, 8'h12, 16'hA5A5, 0, 0, 0);
    if (tm || sl != 10 || !so) begin
      n_err++; $display("FAIL wr_window: len %0d stable %0b tmo %0b want 10 1 0", sl, so, tm);
    end
    n_cmp++;
    if (rs !== 1'b1 || rw !== 1'b1 || !po) begin
      n_err++; $display("FAIL wr_rsp: valid %b we %b pulse %0b want 1 1 1", rs, rw, po);
    end
    n_cmp++;
    drive_access(1'b0, 8'h12, 16'h0000, 0, 0, 0);
    if (tm || sl != 8 || !so) begin
      n_err++; $display("FAIL rd_window: len %0d stable %0b tmo %0b want 8 1 0", sl, so, tm);
    end
    n_cmp++;
    if (rs !== 1'b1 || rw !== 1'b0 || rd !== 16'hA5A5) begin
      n_err++; $display("FAIL rd_rsp: valid %b we %b data %h want 1 0 a5a5", rs, rw, rd);
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    logic        we_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  a_t  [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [15:0] d_t  [4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    int prev_rc;
    for (int i = 0; i < 4; i++) begin
      drive_access(we_t[i], a_t[i], d_t[i], 1, 0, 0);
      if (tm || rb != 0 || !so) begin
        n_err++; $display("FAIL b2b_busy%0d: ready_while_busy %0d stable %0b want 0 1", i, rb, so);
      end
      n_cmp++;
      if (i > 0) begin
        if (ac - prev_rc != 2) begin
          n_err++; $display("FAIL b2b_gap%0d: got %0d want 2", i, ac - prev_rc);
        end
        n_cmp++;
      end
      if (!we_t[i]) begin
        if (rd !== ref_mem[a_t[i]]) begin
          n_err++; $display("FAIL b2b_rdata%0d: got %h want %h", i, rd, ref_mem[a_t[i]]);
        end
        n_cmp++;
      end
      prev_rc = rc;
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_read();
    drive_access(1'b0, 8'h12, 16'h0000, 0, 0, 4);
    if (mem_sel !== 1'b0) begin n_err++; $display("FAIL rstrd_sel: got %b want 0", mem_sel); end
    n_cmp++;
    last_rd = 16'd0;
    @(negedge clk); @(negedge clk);
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'd0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL rstrd_out: valid %b rdata %h ready %b want 0 0000 1",
                        rsp_valid, rsp_rdata, req_ready);
    end
    n_cmp++;
    rst_n = 1'b1;
    @(negedge clk);
    drive_access(1'b0, 8'h12, 16'h0000, 0, 0, 0);
    if (tm || rd !== 16'hA5A5) begin
      n_err++; $display("FAIL rstrd_after: got %h want a5a5", rd);
    end
    n_cmp++;
  endtask

  task automatic test_aborted_write();
    drive_access(1'b1, 8'h12, 16'h1234, 0, 0, 5);
    last_rd = 16'd0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_access(1'b0, 8'h12, 16'h0000, 0, 0, 0);
    if (tm || rd !== 16'hA5A5) begin
      n_err++; $display("FAIL abort_wr: got %h want a5a5", rd);
    end
    n_cmp++;
  endtask

  task automatic test_busy_inputs();
    drive_access(1'b1, 8'h34, 16'h5555, 0, 1, 0);
    if (tm || sl != 10 || !so) begin
      n_err++; $display("FAIL busy_stable: len %0d stable %0b want 10 1", sl, so);
    end
    n_cmp++;
    drive_access(1'b0, 8'h34, 16'h0000, 0, 0, 0);
    if (tm || rd !== 16'h5555) begin
      n_err++; $display("FAIL busy_read: got %h want 5555", rd);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    logic        we;
    logic [7:0]  a;
    logic [15:0] d;
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom);
      a  = 8'(8'h40 + $urandom_range(0, 5));
      d  = 16'($urandom);
      drive_access(we, a, d, 0, 0, 0);
      if (tm || !so || rs !== 1'b1 || rw !== we || sl != (we ? 10 : 8)) begin
        n_err++; $display("FAIL rnd%0d_timing: len %0d we %b valid %b stable %0b want %0d %b 1 1",
                          i, sl, rw, rs, so, we ? 10 : 8, we);
      end
      n_cmp++;
      if (rd !== last_rd) begin
        n_err++; $display("FAIL rnd%0d_rdata: got %h want %h", i, rd, last_rd);
      end
      n_cmp++;
    end
  endtask

  task automatic test_params();
    int hi_q [$];
    int rsp_n = 0;
    p_req_we = 1'b1;
    p_req_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (p_mem_sel) hi_q.push_back(cyc);
      if (p_rsp_valid) rsp_n++;
      if (i == 15) p_req_we = 1'b0;
    end
    p_req_valid = 1'b0;
    if (hi_q.size() < 5 || rsp_n != hi_q.size()) begin
      n_err++; $display("FAIL par_count: sel %0d rsp %0d want >=5 equal", hi_q.size(), rsp_n);
    end
    n_cmp++;
    for (int i = 1; i < hi_q.size(); i++) begin
      if (hi_q[i] - hi_q[i-1] != 5) begin
        n_err++; $display("FAIL par_period%0d: got %0d want 5", i, hi_q[i] - hi_q[i-1]);
      end
      n_cmp++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 16'd0; ref_mem[i] = 16'd0; end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_read();
    test_aborted_write();
    test_busy_inputs();
    test_random();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
